// File: rtl/ise_color_stat.sv
// Per-image colour statistics: classifies each pixel by dominant channel,
// accumulates counts and intensity sums, and emits one record per image.
module ise_color_stat #(
  parameter int unsigned IMG_PIXELS = 16384,
  parameter int unsigned CNT_W      = 15,
  parameter int unsigned SUM_W      = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [4:0]       image_in_index,
  input  logic [23:0]      pixel_in,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [4:0]       rec_index,
  output logic [1:0]       rec_color,
  output logic [SUM_W-1:0] rec_sum
);

  localparam int unsigned CH_W  = 8;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CLS_W = 2;

  localparam logic [CLS_W-1:0] CLS_R = CLS_W'(0);
  localparam logic [CLS_W-1:0] CLS_G = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_B = CLS_W'(2);

  typedef enum logic {ACC, FINAL} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [IDX_W-1:0] idx_lat;

  logic [CH_W-1:0]  ch_r_c, ch_g_c, ch_b_c;
  logic [CLS_W-1:0] pix_class_c;
  logic [CLS_W-1:0] win_c;
  logic [SUM_W-1:0] win_sum_c;
  logic             accept_c;
  logic             last_pix_c;
  logic             load_c;

  assign ch_r_c = pixel_in[23:16];
  assign ch_g_c = pixel_in[15:8];
  assign ch_b_c = pixel_in[7:0];

  // Dominant channel of the incoming pixel; ties favour R, then G.
  always_comb begin
    pix_class_c = CLS_B;
    if (ch_r_c >= ch_g_c && ch_r_c >= ch_b_c) begin
      pix_class_c = CLS_R;
    end else if (ch_g_c >= ch_b_c) begin
      pix_class_c = CLS_G;
    end
  end

  // Image colour is the class with the most pixels, same tie order.
  always_comb begin
    win_c     = CLS_B;
    win_sum_c = sum_b;
    if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
      win_c     = CLS_R;
      win_sum_c = sum_r;
    end else if (cnt_g >= cnt_b) begin
      win_c     = CLS_G;
      win_sum_c = sum_g;
    end
  end

  assign accept_c   = (state == ACC) && pix_valid && !busy;
  assign last_pix_c = accept_c && (pix_cnt == CNT_W'(IMG_PIXELS - 1));
  assign load_c     = (state == FINAL) && (!rec_valid || rec_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last_pix_c) state_nxt = FINAL;
      FINAL:   if (load_c)     state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // busy mirrors FINAL but is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACC;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == FINAL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt   <= '0;
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      idx_lat   <= '0;
      rec_valid <= 1'b0;
      rec_index <= '0;
      rec_color <= '0;
      rec_sum   <= '0;
    end else begin
      if (accept_c) begin
        pix_cnt <= last_pix_c ? '0 : pix_cnt + CNT_W'(1);
        if (pix_cnt == '0) begin
          idx_lat <= image_in_index;
        end
        case (pix_class_c)
          CLS_R: begin
            cnt_r <= cnt_r + CNT_W'(1);
            sum_r <= sum_r + SUM_W'(ch_r_c);
          end
          CLS_G: begin
            cnt_g <= cnt_g + CNT_W'(1);
            sum_g <= sum_g + SUM_W'(ch_g_c);
          end
          default: begin
            cnt_b <= cnt_b + CNT_W'(1);
            sum_b <= sum_b + SUM_W'(ch_b_c);
          end
        endcase
      end

      // A reload may coincide with the sorter taking the previous record.
      if (load_c) begin
        rec_valid <= 1'b1;
        rec_index <= idx_lat;
        rec_color <= win_c;
        rec_sum   <= win_sum_c;
        cnt_r     <= '0;
        cnt_g     <= '0;
        cnt_b     <= '0;
        sum_r     <= '0;
        sum_g     <= '0;
        sum_b     <= '0;
      end else if (rec_valid && rec_ready) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ise_color_stat.sv
// Self-checking bench for ise_color_stat using a reduced image size and a
// per-image reference model built from the pixel list.
module tb_ise_color_stat;

  localparam int unsigned IMG   = 256;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned SUM_W = 16;

  typedef struct packed {
    logic [4:0]       idx;
    logic [1:0]       color;
    logic [SUM_W-1:0] sum;
  } rec_t;

  logic             clk;
  logic             reset;
  logic             pix_valid;
  logic [4:0]       image_in_index;
  logic [23:0]      pixel_in;
  logic             busy;
  logic             rec_valid;
  logic             rec_ready;
  logic [4:0]       rec_index;
  logic [1:0]       rec_color;
  logic [SUM_W-1:0] rec_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] img_q[$];
  rec_t        exp_q[$];
  rec_t        got_q[$];
  logic        mon_en = 1'b0;

  ise_color_stat #(.IMG_PIXELS(IMG), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .image_in_index (image_in_index),
    .pixel_in       (pixel_in),
    .busy           (busy),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_index      (rec_index),
    .rec_color      (rec_color),
    .rec_sum        (rec_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mon_en && !reset && rec_valid && rec_ready)
      got_q.push_back(rec_t'({rec_index, rec_color, rec_sum}));
  end

  // Reference: count classes over the whole image, largest count wins
  // (earliest of R,G,B on ties), report that class's channel total.
  function automatic rec_t model(input logic [4:0] idx);
    int unsigned cnt[3];
    int unsigned sum[3];
    logic [7:0]  ch[3];
    int          c;
    int          best;
    rec_t        r;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      sum[i] = 0;
    end
    foreach (img_q[i]) begin
      ch[0] = img_q[i][23:16];
      ch[1] = img_q[i][15:8];
      ch[2] = img_q[i][7:0];
      if (ch[0] >= ch[1] && ch[0] >= ch[2]) c = 0;
      else if (ch[1] >= ch[2])              c = 1;
      else                                  c = 2;
      cnt[c] += 1;
      sum[c] += int'(ch[c]);
    end
    best = 0;
    for (int i = 1; i < 3; i++)
      if (cnt[i] > cnt[best]) best = i;
    r.idx   = idx;
    r.color = 2'(best);
    r.sum   = SUM_W'(sum[best]);
    return r;
  endfunction

  function automatic logic [7:0] pick_level();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h80;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [23:0] pick_pixel();
    return {pick_level(), pick_level(), pick_level()};
  endfunction

  function automatic rec_t cur_rec();
    return rec_t'({rec_index, rec_color, rec_sum});
  endfunction

  // Present one pixel, hold it through any stall, return after acceptance.
  task automatic send_pix(input logic [23:0] p, input logic [4:0] idx, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid      = 1'b1;
    pixel_in       = p;
    image_in_index = idx;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_pix_stall: busy=%b still high after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  // Later pixels carry a random index, which the design must ignore.
  task automatic send_image(input logic [4:0] idx, input int max_gap);
    foreach (img_q[i])
      send_pix(img_q[i], (i == 0) ? idx : 5'($urandom()),
               (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic fill_const(input logic [23:0] p, input int n);
    for (int i = 0; i < n; i++) img_q.push_back(p);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    image_in_index = '0;
    pixel_in = '0;
    rec_ready = 1'b1;
    #1;
    n_cmp++;
    if ({busy, rec_valid, cur_rec()} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rec_valid=%b rec=%h, required all zero",
               busy, rec_valid, cur_rec());
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Solid red: record timing, busy exactly one cycle, drain on ready.
  task automatic test_solid_red();
    rec_t e;
    img_q.delete();
    fill_const(24'hFF0000, IMG);
    e = model(5'd5);
    send_image(5'd5, 0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL red_final_cycle: busy=%b rec_valid=%b, required busy=1 rec_valid=0", busy, rec_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, rec_valid, cur_rec()} !== {1'b0, 1'b1, e}) begin
      n_fail++;
      $display("FAIL red_record: busy=%b valid=%b rec=%h, required busy=0 valid=1 rec=%h",
               busy, rec_valid, cur_rec(), e);
    end
    n_cmp++;
    if (e.sum !== SUM_W'(255 * IMG) || e.color !== 2'd0) begin
      n_fail++;
      $display("FAIL red_model: model rec=%h, required color=0 sum=%0d", e, 255 * IMG);
    end
    @(negedge clk);
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL red_drain: rec_valid=%b, required 0", rec_valid);
    end
    @(posedge clk); #1;
  endtask

  // Channel tie (grey) and class-count tie (half G, half B).
  task automatic test_ties();
    rec_t e;
    int   n;
    for (int t = 0; t < 2; t++) begin
      img_q.delete();
      if (t == 0) begin
        fill_const(24'h101010, IMG);
        e = '{idx: 5'd9, color: 2'd0, sum: SUM_W'(16 * IMG)};
      end else begin
        fill_const(24'h008000, IMG / 2);
        fill_const(24'h000040, IMG / 2);
        e = '{idx: 5'd17, color: 2'd1, sum: SUM_W'(128 * (IMG / 2))};
      end
      send_image(e.idx, 1);
      n = 0;
      @(negedge clk);
      while (rec_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if ({rec_valid, cur_rec()} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL tie_case%0d: valid=%b rec=%h, required valid=1 rec=%h",
                 t, rec_valid, cur_rec(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Sorter stalled: record 1 held, image 2 waits in FINAL until ready.
  task automatic test_backpressure();
    rec_t e1, e2;
    int   n;
    rec_ready = 1'b0;
    img_q.delete();
    fill_const(24'h000001, IMG);
    e1 = '{idx: 5'd1, color: 2'd2, sum: SUM_W'(IMG)};
    send_image(5'd1, 0);
    n = 0;
    @(negedge clk);
    while (rec_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ({rec_valid, cur_rec()} !== {1'b1, e1}) begin
      n_fail++;
      $display("FAIL bp_rec1: valid=%b rec=%h, required valid=1 rec=%h", rec_valid, cur_rec(), e1);
    end
    img_q.delete();
    fill_const(24'h00FF00, IMG);
    e2 = '{idx: 5'd2, color: 2'd1, sum: SUM_W'(255 * IMG)};
    send_image(5'd2, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, rec_valid, cur_rec()} !== {1'b1, 1'b1, e1}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: busy=%b valid=%b rec=%h, required busy=1 valid=1 rec=%h",
                 k, busy, rec_valid, cur_rec(), e1);
      end
    end
    @(posedge clk); #1;
    rec_ready = 1'b1;
    @(posedge clk); #1;
    rec_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, rec_valid, cur_rec()} !== {1'b0, 1'b1, e2}) begin
      n_fail++;
      $display("FAIL bp_rec2: busy=%b valid=%b rec=%h, required busy=0 valid=1 rec=%h",
               busy, rec_valid, cur_rec(), e2);
    end
    @(posedge clk); #1;
    rec_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: rec_valid=%b, required 0", rec_valid);
    end
  endtask

  // Reset with a pending record and a partial image, then a clean image.
  task automatic test_reset_mid_image();
    rec_t e;
    int   n;
    rec_ready = 1'b0;
    @(posedge clk); #1;
    img_q.delete();
    for (int i = 0; i < IMG; i++) img_q.push_back(24'($urandom()));
    send_image(5'd10, 0);
    img_q.delete();
    for (int i = 0; i < 100; i++) img_q.push_back(24'($urandom()));
    send_image(5'd7, 0);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, rec_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b rec_valid=%b, required 0 0", busy, rec_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    rec_ready = 1'b1;
    img_q.delete();
    fill_const(24'h00FF00, IMG);
    e = '{idx: 5'd3, color: 2'd1, sum: SUM_W'(255 * IMG)};
    send_image(5'd3, 0);
    n = 0;
    @(negedge clk);
    while (rec_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ({rec_valid, cur_rec()} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL reset_clean_image: valid=%b rec=%h, required valid=1 rec=%h",
               rec_valid, cur_rec(), e);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // 32 random images with input gaps and random sorter readiness.
  task automatic test_random();
    logic        done;
    logic [23:0] pa, pb;
    int          mode;
    int          n;
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int im = 0; im < 32; im++) begin
          img_q.delete();
          mode = int'($urandom_range(0, 2));
          pa = pick_pixel();
          pb = pick_pixel();
          for (int i = 0; i < IMG; i++) begin
            case (mode)
              0:       img_q.push_back(24'($urandom()));
              1:       img_q.push_back(pick_pixel());
              default: img_q.push_back(i[0] ? pb : pa);
            endcase
          end
          exp_q.push_back(model(5'(im)));
          send_image(5'(im), 2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rec_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rec_ready = 1'b1;
    n = 0;
    while (got_q.size() < 32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    n_cmp++;
    if (got_q.size() !== 32) begin
      n_fail++;
      $display("FAIL rand_count: got %0d records, required 32", got_q.size());
    end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_rec%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_solid_red();
    test_ties();
    test_backpressure();
    test_reset_mid_image();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ise_color_stat.md
Name: ise_color_stat

Overview:
- Front-end statistics stage of the Image Sorting Engine. It sits directly after the pixel input port and directly before the sorter.
- Consumes the raw 24-bit RGB pixel stream, one image of IMG_PIXELS pixels at a time.
- Classifies every pixel by its dominant channel and accumulates per-colour pixel counts and intensity sums.
- At image end, emits one record {image index, dominant colour, intensity sum} to the sorter over a valid/ready handshake. Back-pressure to the pixel source is via busy.

Parameters:
- IMG_PIXELS, 16384: pixels per image (128x128).
- CNT_W, 15: width of the per-colour pixel counters and the pixel counter. Must hold IMG_PIXELS.
- SUM_W, 22: width of the per-colour intensity sums. Must hold IMG_PIXELS*255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pix_valid  input  1  pixel_in/image_in_index valid this cycle.
- image_in_index  input  5  image number of the current pixel.
- pixel_in  input  24  R=[23:16], G=[15:8], B=[7:0].
- busy  output  1  stall; a pixel is accepted only when pix_valid=1 and busy=0.
- rec_valid  output  1  record register holds an unconsumed record.
- rec_ready  input  1  sorter accepts the record this cycle.
- rec_index  output  5  image index of the record.
- rec_color  output  2  0=R, 1=G, 2=B; value 3 is never produced.
- rec_sum  output  SUM_W  intensity sum for rec_color.

Behaviour:
- Reset (async, active-high):
  - state=ACC.
  - busy, rec_valid, rec_index, rec_color, rec_sum all 0.
  - Pixel counter, all three count registers, all three sum registers and the latched index cleared.
- Pixel classification (combinational on an accepted pixel):
  - R if R>=G and R>=B; else G if G>=B; else B.
  - Ties therefore resolve R > G > B.
- Accept (state ACC, pix_valid=1, busy=0):
  - cnt[c] += 1 and sum[c] += value of channel c, where c is the pixel's class.
  - Pixel counter increments.
  - On the first pixel of an image (pixel counter=0), latch image_in_index. image_in_index is ignored on all later pixels of that image.
  - On the pixel where the counter equals IMG_PIXELS-1, go to FINAL in the next cycle and wrap the counter to 0.
- States:
  - ACC: busy=0.
  - FINAL: busy=1, so no pixel is accepted.
- Image colour: colour with the largest cnt. Ties resolve R > G > B. Chosen sum = sum[winner].
- FINAL exit:
  - If rec_valid=0, or rec_valid=1 and rec_ready=1 in the same cycle: load rec_index/rec_color/rec_sum from the latched index, the winner and the chosen sum.
  - In that case set rec_valid=1, clear all counts and sums, and go to ACC.
  - Otherwise stay in FINAL, with busy held high and accumulators untouched.
- Minimum FINAL duration is 1 cycle, so steady state is IMG_PIXELS+1 cycles per image.
- Record handshake:
  - rec_valid=1 and rec_ready=1 (outside a reload) → rec_valid=0 next cycle.
  - Record outputs stay stable while rec_valid=1 and rec_ready=0.
- rec_ready while rec_valid=0 has no effect.
- pix_valid while busy=1: no acceptance, no state change. The source must hold the pixel.
- Reset mid-image or mid-FINAL: all partial statistics are discarded and any pending record is dropped.
- Arithmetic: unsigned. Counters and sums are sized so they never overflow for IMG_PIXELS pixels; no saturation logic.

Test Plan:
- 16384 pixels of 0xFF0000, index 5, rec_ready=1 → one record: idx=5, color=0, sum=0x3FC000 (4177920). busy high for exactly 1 cycle after the last pixel.
- 16384 pixels of 0x101010, index 9 → color=0 (tie→R), sum=262144.
- 8192 pixels of 0x008000 then 8192 of 0x000040, index 17 → count tie G/B → color=1, sum=1048576.
- rec_ready=0 throughout, two full images (index 1 all-blue 0x000001, then index 2 all-green):
  - Record 1 held stable: color=2, sum=16384.
  - At the end of image 2, busy stays 1 until rec_ready pulses.
  - Then record 2 loads: idx=2, color=1.
- Assert reset after 100 accepted pixels → busy=0 and rec_valid=0 immediately. A following full 0x00FF00 image, index 3, yields color=1, sum=4177920, with no residue from the aborted image.
- Random pix_valid gaps and 32 random images → records match the reference model in order, idx 0..31.
